// File: rtl/inst_mem_boot_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
// Fetch bus widths, reset/enable levels and the loader state encoding.
package inst_mem_boot_pkg;

    localparam int          INST_ADDR_W  = 32;
    localparam int          INST_W       = 32;
    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;
    localparam int          BOOT_STATE_W = 3;

    typedef enum logic [BOOT_STATE_W-1:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        RUN    = 3'd3,
        ERR    = 3'd4
    } boot_state_e;

    // Join the three buffered bytes with the incoming one, big-endian.
    function automatic logic [31:0] be_assemble(input logic [23:0] shift,
                                                input logic [7:0]  byte_in);
        return {shift, byte_in};
    endfunction

endpackage

// File: rtl/inst_mem_boot_if.sv
// Fetch port and loader byte stream of the boot instruction memory.
// master = core/loader side, slave = memory side.
interface inst_mem_boot_if;
    import inst_mem_boot_pkg::*;

    logic                   ce_i;
    logic [INST_ADDR_W-1:0] addr_i;
    logic [INST_W-1:0]      inst_o;
    logic                   byte_valid_i;
    logic [7:0]             byte_i;
    logic                   byte_ready_o;
    logic                   cpu_rst_o;
    logic                   load_done_o;
    logic                   err_o;

    modport master (
        output ce_i, addr_i, byte_valid_i, byte_i,
        input  inst_o, byte_ready_o, cpu_rst_o, load_done_o, err_o
    );

    modport slave (
        input  ce_i, addr_i, byte_valid_i, byte_i,
        output inst_o, byte_ready_o, cpu_rst_o, load_done_o, err_o
    );

endinterface

// File: rtl/inst_mem_array.sv
// 2^AW x 32 storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the owner masks unloaded words.
module inst_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [0:(2**AW)-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_mem_boot.sv
// Instruction memory filled from a big-endian byte stream (count, then words),
// holding the core in reset until the load finishes, then serving fetches.
module inst_mem_boot
    import inst_mem_boot_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst,
    inst_mem_boot_if.slave  bus
);

    localparam logic [16:0] DEPTH = 17'd1 << AW;

    boot_state_e  state_r;
    logic [15:0]  word_cnt_r;
    logic [15:0]  wr_idx_r;
    logic [1:0]   byte_idx_r;
    logic [23:0]  shift_r;
    logic         byte_ready_r;
    logic         cpu_rst_r;
    logic         load_done_r;
    logic         err_r;

    logic         xfer_s;
    logic [15:0]  n_s;
    logic [15:0]  wr_idx_nxt_s;
    logic         we_s;
    logic [31:0]  wdata_s;
    logic [AW-1:0] widx_s;
    logic [31:0]  rdata_s;
    logic         hit_s;
    logic [31:0]  inst_s;
    logic         unused_s;

    assign xfer_s       = bus.byte_valid_i & byte_ready_r;
    assign n_s          = {word_cnt_r[15:8], bus.byte_i};
    assign wr_idx_nxt_s = wr_idx_r + 16'd1;
    assign wdata_s      = be_assemble(shift_r, bus.byte_i);
    assign widx_s       = bus.addr_i[AW+1:2];
    assign unused_s     = &{1'b0, bus.addr_i[INST_ADDR_W-1:AW+2], bus.addr_i[1:0]};

    // Write strobe: fires on the fourth byte of each word while loading.
    always_comb begin
        we_s = 1'b0;
        if ((state_r == DATA) && xfer_s && (byte_idx_r == 2'd3)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    inst_mem_array #(.AW(AW)) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_idx_r[AW-1:0]),
        .wdata (wdata_s),
        .raddr (widx_s),
        .rdata (rdata_s)
    );

    // Loader FSM; status outputs are registered together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r      <= LEN_HI;
            word_cnt_r   <= 16'd0;
            wr_idx_r     <= 16'd0;
            byte_idx_r   <= 2'd0;
            shift_r      <= 24'd0;
            byte_ready_r <= 1'b1;
            cpu_rst_r    <= 1'b1;
            load_done_r  <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                LEN_HI: begin
                    if (xfer_s) begin
                        word_cnt_r[15:8] <= bus.byte_i;
                        state_r          <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer_s) begin
                        word_cnt_r[7:0] <= bus.byte_i;
                        wr_idx_r        <= 16'd0;
                        byte_idx_r      <= 2'd0;
                        if (n_s == 16'd0) begin
                            state_r      <= RUN;
                            byte_ready_r <= 1'b0;
                            cpu_rst_r    <= 1'b0;
                            load_done_r  <= 1'b1;
                        end else if ({1'b0, n_s} > DEPTH) begin
                            state_r      <= ERR;
                            byte_ready_r <= 1'b0;
                            err_r        <= 1'b1;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        shift_r    <= {shift_r[15:0], bus.byte_i};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            wr_idx_r <= wr_idx_nxt_s;
                            if (wr_idx_nxt_s == word_cnt_r) begin
                                state_r      <= RUN;
                                byte_ready_r <= 1'b0;
                                cpu_rst_r    <= 1'b0;
                                load_done_r  <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    byte_ready_r <= 1'b0;
                    cpu_rst_r    <= 1'b0;
                    load_done_r  <= 1'b1;
                end
                ERR: begin
                    byte_ready_r <= 1'b0;
                    cpu_rst_r    <= 1'b1;
                    err_r        <= 1'b1;
                end
                default: begin
                    // Unknown encoding: park in ERR so the core stays held.
                    state_r      <= ERR;
                    byte_ready_r <= 1'b0;
                    cpu_rst_r    <= 1'b1;
                    load_done_r  <= 1'b0;
                    err_r        <= 1'b1;
                end
            endcase
        end
    end

    assign hit_s = (bus.ce_i == CHIP_ENABLE) && (state_r == RUN) &&
                   ({{(16-AW){1'b0}}, widx_s} < word_cnt_r);

    // Fetch mask: only loaded words are visible, and only once running.
    always_comb begin
        inst_s = INST_NOP;
        if (hit_s) begin
            inst_s = rdata_s;
        end else begin
            inst_s = INST_NOP;
        end
    end

    assign bus.inst_o       = inst_s;
    assign bus.byte_ready_o = byte_ready_r;
    assign bus.cpu_rst_o    = cpu_rst_r;
    assign bus.load_done_o  = load_done_r;
    assign bus.err_o        = err_r;

endmodule

// File: tb/tb_inst_mem_boot.sv
// Directed bench for inst_mem_boot: loads, error count, mid-load reset, fetch masking.
module tb_inst_mem_boot;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    logic [7:0] stream10 [10];

    inst_mem_boot_if bus ();

    inst_mem_boot #(.AW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid_i = 1'b1;
        bus.byte_i = b;
        check_val("byte_ready", {31'd0, bus.byte_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic ce, input logic [31:0] addr,
                         input logic [31:0] exp);
        bus.ce_i = ce;
        bus.addr_i = addr;
        #1;
        check_val(tag, bus.inst_o, exp);
    endtask

    task automatic load10(input bit gap);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check_val("cpu_rst_before_last", {31'd0, bus.cpu_rst_o}, 32'd1);
            send_byte(stream10[i]);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
        check_val("cpu_rst_after_load", {31'd0, bus.cpu_rst_o}, 32'd0);
        check_val("load_done", {31'd0, bus.load_done_o}, 32'd1);
        check_val("ready_after_load", {31'd0, bus.byte_ready_o}, 32'd0);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt = 0;
        stream10 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
        rst = 1'b1;
        bus.ce_i = 1'b1;
        bus.addr_i = 32'h0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'h00;

        // Outputs while reset is held
        @(posedge clk);
        #1;
        check_val("rst_ready", {31'd0, bus.byte_ready_o}, 32'd1);
        check_val("rst_cpu_rst", {31'd0, bus.cpu_rst_o}, 32'd1);
        check_val("rst_done", {31'd0, bus.load_done_o}, 32'd0);
        check_val("rst_err", {31'd0, bus.err_o}, 32'd0);
        check_val("rst_inst", bus.inst_o, 32'h0);
        rst = 1'b0;

        // Back-to-back load of two words
        load10(1'b0);
        fetch("t1_a0", 1'b1, 32'h0, 32'h3401_1100);
        fetch("t1_a4", 1'b1, 32'h4, 32'h3402_0020);
        fetch("t1_a8", 1'b1, 32'h8, 32'h0000_0000);

        // Same load with byte_valid toggling
        do_reset();
        fetch("t2_loading", 1'b1, 32'h0, 32'h0);
        load10(1'b1);
        fetch("t2_a0", 1'b1, 32'h0, 32'h3401_1100);
        fetch("t2_a4", 1'b1, 32'h4, 32'h3402_0020);
        fetch("t2_a8", 1'b1, 32'h8, 32'h0000_0000);

        // Zero-length program
        do_reset();
        send_byte(8'h00);
        check_val("t3_cpu_rst_mid", {31'd0, bus.cpu_rst_o}, 32'd1);
        send_byte(8'h00);
        check_val("t3_cpu_rst", {31'd0, bus.cpu_rst_o}, 32'd0);
        check_val("t3_done", {31'd0, bus.load_done_o}, 32'd1);
        fetch("t3_a0", 1'b1, 32'h0, 32'h0);
        fetch("t3_a4", 1'b1, 32'h4, 32'h0);

        // Count one past depth
        do_reset();
        send_byte(8'h04);
        send_byte(8'h01);
        check_val("t4_err", {31'd0, bus.err_o}, 32'd1);
        check_val("t4_ready", {31'd0, bus.byte_ready_o}, 32'd0);
        check_val("t4_cpu_rst", {31'd0, bus.cpu_rst_o}, 32'd1);
        check_val("t4_done", {31'd0, bus.load_done_o}, 32'd0);
        bus.byte_valid_i = 1'b1;
        bus.byte_i = 8'h55;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        check_val("t4_err_sticky", {31'd0, bus.err_o}, 32'd1);
        fetch("t4_a0", 1'b1, 32'h0, 32'h0);

        // Reset mid-load, then reload a single word
        do_reset();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'h11);
        send_byte(8'h22);
        fetch("t5_midload", 1'b1, 32'h0, 32'h0);
        do_reset();
        check_val("t5_cpu_rst", {31'd0, bus.cpu_rst_o}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check_val("t5_done", {31'd0, bus.load_done_o}, 32'd1);
        fetch("t5_a0", 1'b1, 32'h0, 32'hDEAD_BEEF);
        fetch("t5_a4_stale", 1'b1, 32'h4, 32'h0);

        // Fetch gating and aliasing
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        fetch("t6_ce0", 1'b0, 32'h0, 32'h0);
        fetch("t6_alias", 1'b1, 32'h1000, 32'h1122_3344);
        fetch("t6_a3", 1'b1, 32'h3, 32'h1122_3344);
        fetch("t6_a4", 1'b1, 32'h4, 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
